// File: rtl/cmd_fetch_pkg.sv
// Shared types and constants for the command fetcher: state encoding, opcode
// limits, error codes and the opcode -> argument-count table.
package cmd_fetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH_OP  = 3'd1,
        ST_LATCH_OP  = 3'd2,
        ST_FETCH_ARG = 3'd3,
        ST_LATCH_ARG = 3'd4,
        ST_EXEC      = 3'd5,
        ST_END       = 3'd6,
        ST_ERROR     = 3'd7
    } state_e;

    localparam logic [7:0] OP_END = 8'h00;
    localparam logic [7:0] OP_MAX = 8'h10;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL  = 2'd1;
    localparam logic [1:0] ERR_OVERFLOW = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

    // Returns {illegal, count[2:0]}; opcodes 1..16 fall into four groups of four.
    function automatic logic [3:0] arg_count_f(input logic [7:0] op);
        logic [7:0] idx;
        logic [3:0] r;
        idx = op - 8'd1;
        r   = 4'b0000;
        if (op == OP_END) begin
            r = 4'b0000;
        end else if (op > OP_MAX) begin
            r = 4'b1000;
        end else begin
            case (idx[3:2])
                2'd0:    r = 4'd0;
                2'd1:    r = 4'd1;
                2'd2:    r = 4'd2;
                default: r = 4'd4;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/cmd_arg_count.sv
// Combinational opcode decode: number of argument bytes plus an illegal flag.
module cmd_arg_count
    import cmd_fetch_pkg::*;
(
    input  logic [7:0] opcode,
    output logic [2:0] arg_count,
    output logic       illegal
);

    logic [3:0] result;

    assign result    = arg_count_f(opcode);
    assign arg_count = result[2:0];
    assign illegal   = result[3];

endmodule

// File: rtl/command_fetcher.sv
// Walks a byte-coded command program in synchronous RAM and hands each opcode
// plus packed arguments to the executor. Optional watchdog: CMD_FETCH_TIMEOUT_EN.
//
// Handshake: cmd_valid rises in EXEC and stays high until cmd_done is seen in
// an EXEC cycle (the first one included); cmd_done outside EXEC is ignored.
module command_fetcher
    import cmd_fetch_pkg::*;
#(
    parameter int ADDR_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic                  abort,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] addr_out,
    input  logic [7:0]            data_in,
    output logic [7:0]            opcode_out,
    output logic [31:0]           arg_out,
    output logic                  cmd_valid,
    input  logic                  cmd_done,
    output logic                  busy,
    output logic                  prog_done,
    output logic                  error,
    output logic [1:0]            err_code
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            opcode_q, opcode_d;
    logic [31:0]           arg_q, arg_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [1:0]            lane_q, lane_d;
    logic                  ovf_q, ovf_d;
    logic                  prog_done_q, prog_done_d;
    logic                  error_q, error_d;
    logic [1:0]            err_q, err_d;

    logic [2:0]            op_args;
    logic                  op_illegal;
    logic                  addr_max;
    logic [ADDR_WIDTH-1:0] addr_inc;
    logic                  tmo_hit;

    cmd_arg_count u_arg_count (
        .opcode    (data_in),
        .arg_count (op_args),
        .illegal   (op_illegal)
    );

    assign addr_max = &addr_q;
    assign addr_inc = addr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

`ifdef CMD_FETCH_TIMEOUT_EN
    localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);
    logic [15:0] tmo_q, tmo_d;

    assign tmo_hit = (state_q == ST_EXEC) && !cmd_done && ((tmo_q + 16'd1) == TMO_LIMIT);

    always_comb begin
        tmo_d = tmo_q;
        if (state_q != ST_EXEC) begin
            tmo_d = 16'd0;
        end else if (!cmd_done) begin
            tmo_d = tmo_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) tmo_q <= 16'd0;
        else          tmo_q <= tmo_d;
    end
`else
    logic unused_tmo;
    assign unused_tmo = ^{TIMEOUT_CYCLES[15:0], ERR_TIMEOUT};
    assign tmo_hit    = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        opcode_d    = opcode_q;
        arg_d       = arg_q;
        cnt_d       = cnt_q;
        lane_d      = lane_q;
        ovf_d       = ovf_q;
        prog_done_d = prog_done_q;
        error_d     = error_q;
        err_d       = err_q;

        if (abort) begin
            state_d     = ST_IDLE;
            prog_done_d = 1'b0;
            error_d     = 1'b0;
            err_d       = ERR_NONE;
        end else begin
            case (state_q)
                ST_IDLE, ST_END, ST_ERROR: begin
                    if (start) begin
                        state_d     = ST_FETCH_OP;
                        addr_d      = start_addr;
                        arg_d       = 32'd0;
                        ovf_d       = 1'b0;
                        prog_done_d = 1'b0;
                        error_d     = 1'b0;
                        err_d       = ERR_NONE;
                    end
                end
                ST_FETCH_OP: begin
                    // A pending overflow means the next opcode lies past the top of memory.
                    if (ovf_q) begin
                        state_d = ST_ERROR;
                        error_d = 1'b1;
                        err_d   = ERR_OVERFLOW;
                    end else begin
                        state_d = ST_LATCH_OP;
                    end
                end
                ST_LATCH_OP: begin
                    opcode_d = data_in;
                    if (data_in == OP_END) begin
                        state_d     = ST_END;
                        prog_done_d = 1'b1;
                    end else if (op_illegal) begin
                        state_d = ST_ERROR;
                        error_d = 1'b1;
                        err_d   = ERR_ILLEGAL;
                    end else begin
                        arg_d  = 32'd0;
                        cnt_d  = op_args;
                        lane_d = 2'd0;
                        if (op_args == 3'd0) begin
                            state_d = ST_EXEC;
                            addr_d  = addr_max ? addr_q : addr_inc;
                            ovf_d   = addr_max;
                        end else if (addr_max) begin
                            state_d = ST_ERROR;
                            error_d = 1'b1;
                            err_d   = ERR_OVERFLOW;
                        end else begin
                            state_d = ST_FETCH_ARG;
                            addr_d  = addr_inc;
                        end
                    end
                end
                ST_FETCH_ARG: begin
                    state_d = ST_LATCH_ARG;
                end
                ST_LATCH_ARG: begin
                    arg_d[{lane_q, 3'b000} +: 8] = data_in;
                    lane_d = lane_q + 2'd1;
                    cnt_d  = cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        state_d = ST_EXEC;
                        addr_d  = addr_max ? addr_q : addr_inc;
                        ovf_d   = addr_max;
                    end else if (addr_max) begin
                        state_d = ST_ERROR;
                        error_d = 1'b1;
                        err_d   = ERR_OVERFLOW;
                    end else begin
                        state_d = ST_FETCH_ARG;
                        addr_d  = addr_inc;
                    end
                end
                ST_EXEC: begin
                    if (cmd_done) begin
                        state_d = ST_FETCH_OP;
                    end else if (tmo_hit) begin
                        state_d = ST_ERROR;
                        error_d = 1'b1;
                        err_d   = ERR_TIMEOUT;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            opcode_q    <= 8'd0;
            arg_q       <= 32'd0;
            cnt_q       <= 3'd0;
            lane_q      <= 2'd0;
            ovf_q       <= 1'b0;
            prog_done_q <= 1'b0;
            error_q     <= 1'b0;
            err_q       <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            opcode_q    <= opcode_d;
            arg_q       <= arg_d;
            cnt_q       <= cnt_d;
            lane_q      <= lane_d;
            ovf_q       <= ovf_d;
            prog_done_q <= prog_done_d;
            error_q     <= error_d;
            err_q       <= err_d;
        end
    end

    assign rd_en      = ((state_q == ST_FETCH_OP) && !ovf_q) || (state_q == ST_FETCH_ARG);
    assign cmd_valid  = (state_q == ST_EXEC);
    assign busy       = !((state_q == ST_IDLE) || (state_q == ST_END) || (state_q == ST_ERROR));
    assign addr_out   = addr_q;
    assign opcode_out = opcode_q;
    assign arg_out    = arg_q;
    assign prog_done  = prog_done_q;
    assign error      = error_q;
    assign err_code   = err_q;

endmodule

// File: tb/tb_command_fetcher.sv
// Directed bench for command_fetcher: byte RAM model, hand-computed cycle
// expectations for fetch latency, argument packing, faults, abort and reset.
module tb_command_fetcher;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [15:0] start_addr;
    logic        abort;
    logic        rd_en;
    logic [15:0] addr_out;
    logic [7:0]  data_in;
    logic [7:0]  opcode_out;
    logic [31:0] arg_out;
    logic        cmd_valid;
    logic        cmd_done;
    logic        busy;
    logic        prog_done;
    logic        error;
    logic [1:0]  err_code;

    logic [7:0]  mem [0:65535];
    int          n_checks;
    int          n_fail;
    int          wrap_reads;
    int          valid_cnt;
    int          wrap_base;

    command_fetcher #(
        .ADDR_WIDTH     (16),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .start_addr (start_addr),
        .abort      (abort),
        .rd_en      (rd_en),
        .addr_out   (addr_out),
        .data_in    (data_in),
        .opcode_out (opcode_out),
        .arg_out    (arg_out),
        .cmd_valid  (cmd_valid),
        .cmd_done   (cmd_done),
        .busy       (busy),
        .prog_done  (prog_done),
        .error      (error),
        .err_code   (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM: data one cycle after rd_en; also counts reads at the wrapped address.
    always @(posedge clk) begin
        if (rd_en) begin
            data_in <= mem[addr_out];
            if (addr_out == 16'h0000) wrap_reads <= wrap_reads + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Returns in cycle 1 (FETCH_OP) with start pulsed during cycle 0.
    task automatic launch(input logic [15:0] a);
        tick();
        start      = 1'b1;
        start_addr = a;
        tick();
        start      = 1'b0;
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        wrap_reads = 0;
        data_in    = 8'h00;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h0100] = 8'h01; mem[16'h0101] = 8'h00;
        mem[16'h0200] = 8'h0D; mem[16'h0201] = 8'h11; mem[16'h0202] = 8'h22;
        mem[16'h0203] = 8'h33; mem[16'h0204] = 8'h44; mem[16'h0205] = 8'h00;
        mem[16'h0300] = 8'h06; mem[16'h0301] = 8'hAB; mem[16'h0302] = 8'h7F;
        mem[16'h0000] = 8'h55;

        reset_n    = 1'b0;
        start      = 1'b0;
        start_addr = 16'h0000;
        abort      = 1'b0;
        cmd_done   = 1'b0;
        #12;
        check("rst_outputs", {rd_en, addr_out, opcode_out, cmd_valid, busy, prog_done, error, err_code},
              32'd0);
        check("rst_arg", arg_out, 32'd0);
        reset_n = 1'b1;

        // 0-arg opcode then end of program
        launch(16'h0100);
        sample(); check("t1_c1_rd_en", rd_en, 1); check("t1_c1_addr", addr_out, 16'h0100);
        check("t1_c1_busy", busy, 1);
        tick(); sample(); check("t1_c2_valid", cmd_valid, 0);
        tick(); sample(); check("t1_c3_valid", cmd_valid, 1); check("t1_opcode", opcode_out, 8'h01);
        check("t1_arg", arg_out, 32'd0);
        cmd_done = 1'b1;
        tick(); cmd_done = 1'b0;
        sample(); check("t1_c4_valid", cmd_valid, 0); check("t1_c4_rd_en", rd_en, 1);
        check("t1_c4_addr", addr_out, 16'h0101);
        tick(); tick(); sample();
        check("t1_prog_done", prog_done, 1); check("t1_busy", busy, 0); check("t1_end_op", opcode_out, 8'h00);

        // 4-argument opcode, little-endian packing
        launch(16'h0200);
        sample(); check("t2_prog_done_cleared", prog_done, 0);
        repeat (9) tick();
        sample(); check("t2_c10_valid", cmd_valid, 0);
        tick(); sample();
        check("t2_c11_valid", cmd_valid, 1); check("t2_opcode", opcode_out, 8'h0D);
        check("t2_arg", arg_out, 32'h44332211); check("t2_addr", addr_out, 16'h0205);
        cmd_done = 1'b1;
        tick(); cmd_done = 1'b0;
        tick(); tick(); sample();
        check("t2_prog_done", prog_done, 1); check("t2_busy", busy, 0);

        // 1-arg opcode followed by illegal opcode
        launch(16'h0300);
        repeat (4) tick();
        sample(); check("t3_c5_valid", cmd_valid, 1); check("t3_arg", arg_out, 32'h000000AB);
        check("t3_opcode", opcode_out, 8'h06);
        cmd_done = 1'b1;
        tick(); cmd_done = 1'b0;
        sample(); check("t3_c6_valid", cmd_valid, 0);
        tick(); sample(); check("t3_c7_valid", cmd_valid, 0);
        tick(); sample();
        check("t3_error", error, 1); check("t3_err_code", err_code, 2'd1);
        check("t3_opcode_7f", opcode_out, 8'h7F); check("t3_c8_valid", cmd_valid, 0);
        check("t3_busy", busy, 0); check("t3_prog_done", prog_done, 0);
        tick(); sample(); check("t3_hold_valid", cmd_valid, 0); check("t3_hold_err", err_code, 2'd1);

        // 2-arg opcode at the top of memory: overflow before any argument read
        mem[16'hFFFF] = 8'h09;
        wrap_base = wrap_reads;
        launch(16'hFFFF);
        sample(); check("t4_c1_addr", addr_out, 16'hFFFF); check("t4_c1_rd_en", rd_en, 1);
        tick(); tick(); sample();
        check("t4_error", error, 1); check("t4_err_code", err_code, 2'd2);
        check("t4_rd_en", rd_en, 0); check("t4_valid", cmd_valid, 0);
        tick(); tick(); sample();
        check("t4_no_wrap_read", wrap_reads - wrap_base, 0);

        // 0-arg opcode at the top of memory: executes, then overflow at next fetch
        mem[16'hFFFF] = 8'h01;
        launch(16'hFFFF);
        sample(); check("t4b_error_cleared", error, 0);
        tick(); tick(); sample();
        check("t4b_valid", cmd_valid, 1); check("t4b_opcode", opcode_out, 8'h01);
        cmd_done = 1'b1;
        tick(); cmd_done = 1'b0;
        sample(); check("t4b_c4_rd_en", rd_en, 0);
        tick(); sample();
        check("t4b_error", error, 1); check("t4b_err_code", err_code, 2'd2);
        tick(); tick(); sample();
        check("t4b_no_wrap_read", wrap_reads - wrap_base, 0);

        // abort out of ERROR clears sticky flags
        tick(); abort = 1'b1;
        tick(); abort = 1'b0;
        sample(); check("t5_abort_error", error, 0); check("t5_abort_code", err_code, 2'd0);
        check("t5_abort_busy", busy, 0);

        // abort and start together: abort wins
        tick(); abort = 1'b1; start = 1'b1; start_addr = 16'h0100;
        tick(); abort = 1'b0; start = 1'b0;
        sample(); check("t5_both_busy", busy, 0); check("t5_both_rd_en", rd_en, 0);
        tick(); sample(); check("t5_both_busy2", busy, 0);

        // abort while cmd_valid is high
        launch(16'h0100);
        tick(); tick(); sample(); check("t5_exec_valid", cmd_valid, 1);
        abort = 1'b1;
        tick(); abort = 1'b0;
        sample(); check("t5_abort_valid", cmd_valid, 0); check("t5_abort_busy2", busy, 0);
        check("t5_abort_rd_en", rd_en, 0);

        // cmd_done withheld; start while busy must be ignored
        launch(16'h0100);
        tick(); tick(); sample(); check("t6_valid", cmd_valid, 1);
        start = 1'b1; start_addr = 16'h0300;
        tick(); start = 1'b0;
        valid_cnt = 1;
        for (int i = 0; i < 99; i++) begin
            sample();
            if (cmd_valid) valid_cnt++;
            tick();
        end
        sample();
`ifdef CMD_FETCH_TIMEOUT_EN
        check("t6_valid_cycles", valid_cnt, 8);
        check("t6_err_code", err_code, 2'd3);
        check("t6_error", error, 1);
`else
        check("t6_valid_cycles", valid_cnt, 100);
        check("t6_err_code", err_code, 2'd0);
        check("t6_addr", addr_out, 16'h0101);
        check("t6_valid_end", cmd_valid, 1);
`endif

        // asynchronous reset mid-operation
        launch(16'h0200);
        repeat (3) tick();
        reset_n = 1'b0;
        #1;
        check("t7_rst_outputs", {rd_en, addr_out, opcode_out, cmd_valid, busy, prog_done, error, err_code},
              32'd0);
        check("t7_rst_arg", arg_out, 32'd0);
        tick(); reset_n = 1'b1;
        tick(); sample(); check("t7_idle_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/command_fetcher.md
Name: command_fetcher

Overview:
- Upstream stage of command_decoder in the executor.
- Walks a byte-coded command program in synchronous RAM and fetches each opcode byte plus its argument bytes.
- Presents the opcode (which drives command_decoder's data_in) and the packed arguments to the executor with a valid/done handshake.
- Stops on the end-of-program opcode, an illegal opcode, or address overflow.

Parameters:
- ADDR_WIDTH, 16, RAM byte-address width.
- TIMEOUT_CYCLES, 65535, cmd_done watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins fetching at start_addr; ignored unless IDLE/END/ERROR.
- start_addr  in  ADDR_WIDTH  first program byte address.
- abort  in  1  synchronous abort; returns to IDLE.
- rd_en  out  1  RAM read strobe.
- addr_out  out  ADDR_WIDTH  RAM byte address.
- data_in  in  8  RAM read data, valid one cycle after rd_en.
- opcode_out  out  8  current opcode, to command_decoder.
- arg_out  out  32  argument bytes, little-endian (first byte in [7:0]); unused bytes are 0.
- cmd_valid  out  1  opcode_out/arg_out valid; held until cmd_done.
- cmd_done  in  1  executor finished the current command.
- busy  out  1  high in any state except IDLE/END/ERROR.
- prog_done  out  1  sticky; 0x00 opcode reached.
- error  out  1  sticky fault flag.
- err_code  out  2  0 none, 1 illegal opcode, 2 address overflow, 3 timeout.

Behaviour:
- Reset (async, reset_n low): state IDLE. All outputs 0: addr_out, rd_en, opcode_out, arg_out, cmd_valid, busy, prog_done, error, err_code.
- Argument count is a fixed table:
  - 0x01–0x04: 0 bytes
  - 0x05–0x08: 1 byte
  - 0x09–0x0C: 2 bytes
  - 0x0D–0x10: 4 bytes
  - 0x00: end of program
  - 0x11–0xFF: illegal
- IDLE/END/ERROR + start: load addr_out←start_addr; clear prog_done, error, err_code, arg_out; go to FETCH_OP.
- FETCH_OP: rd_en=1 → LATCH_OP.
- LATCH_OP: capture data_in into opcode_out.
  - 0x00 → END, prog_done=1.
  - Illegal → ERROR, code 1.
  - Otherwise addr_out+1, clear arg_out, load the argument counter; count 0 → EXEC, else FETCH_ARG.
- FETCH_ARG: rd_en=1 → LATCH_ARG.
- LATCH_ARG: write data_in into the next arg_out byte lane; addr_out+1; decrement the counter; when it reaches 0 → EXEC, else FETCH_ARG.
- EXEC: cmd_valid=1. When cmd_done=1 (including the first EXEC cycle): cmd_valid drops next cycle → FETCH_OP. cmd_done outside EXEC is ignored.
- Latency:
  - start (cycle 0) → FETCH_OP (1) → LATCH_OP (2) → cmd_valid in cycle 3 for a 0-arg opcode.
  - Each argument byte adds 2 cycles.
  - cmd_done to the next rd_en is 1 cycle.
- Address overflow: an increment from all-ones needed to fetch another byte → ERROR, code 2; no wrap-around fetch. An increment from all-ones when the just-latched 0-arg opcode goes to EXEC is allowed; overflow is raised at the next FETCH_OP.
- abort: from any state, next cycle IDLE, cmd_valid=0, rd_en=0. prog_done, error and err_code are cleared.
- abort and start in the same cycle: abort wins.
- Reset mid-operation: immediate IDLE, all outputs 0.
- END/ERROR: outputs hold; busy=0; only start or abort leaves.

Optional Feature:
- Macro: CMD_FETCH_TIMEOUT_EN.
- Defined: a 16-bit counter clears on entering EXEC and increments each EXEC cycle without cmd_done. When it reaches TIMEOUT_CYCLES: cmd_valid=0, ERROR, code 3.
- Not defined: no counter; EXEC waits indefinitely; code 3 never produced.

Decomposition:
- Package cmd_fetch_pkg holds:
  - State encoding localparams.
  - Opcode constants: OP_END=8'h00, OP_MAX=8'h10.
  - Err-code constants.
  - Argument-count function.
- Natural sub-module: cmd_arg_count (combinational opcode → 3-bit count plus illegal flag), shared with future assembler checks.
- The FSM stays in command_fetcher.

Test Plan:
- RAM {0x01,0x00} at 0x0100, start_addr=0x0100 → cmd_valid in cycle 3 with opcode 0x01, arg_out 0; cmd_done → rd_en at 0x0101, then prog_done=1, busy=0.
- RAM {0x0D,0x11,0x22,0x33,0x44,0x00} → arg_out=0x44332211, cmd_valid 11 cycles after start; after cmd_done, END.
- RAM {0x06,0xAB,0x7F} → first command arg_out=0x000000AB; then error=1, err_code=1, opcode_out=0x7F, cmd_valid never asserted for 0x7F.
- Opcode 0x09 at address 0xFFFF (ADDR_WIDTH=16) → ERROR, err_code=2 before any argument read; rd_en never at wrapped 0x0000.
- abort asserted in EXEC while cmd_valid=1 → next cycle IDLE, cmd_valid=0; abort and start in the same IDLE cycle → stays IDLE.
- With CMD_FETCH_TIMEOUT_EN and TIMEOUT_CYCLES=8: cmd_done withheld → cmd_valid drops after 8 EXEC cycles, err_code=3. Without the macro, cmd_valid stays high for 100 cycles.
